// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns: takes a 128-bit state, transforms
// one 32-bit column per clock, then holds the result until the consumer takes it.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [1:0]   dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid and its data stay stable until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic [1:0]   col_cnt_q;
    logic [127:0] src_q;
    logic         inv_q;
    logic [127:0] res_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [6:0]   col_base;
    logic [31:0]  col_a;
    logic [31:0]  col_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients used here never exceed 0x0E, so four xtime-chain terms suffice.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a [4];
        logic [3:0] coef [4];
        logic [7:0] b;
        logic [1:0] idx;
        logic [31:0] res;
        res = 32'h0;
        for (int r = 0; r < 4; r++) begin
            a[r] = col[31-8*r -: 8];
        end
        if (inv) begin
            coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
        end else begin
            coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
        end
        for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) begin
                idx = 2'(r + j);
                b = b ^ gf_mul(a[idx], coef[j]);
            end
            res[31-8*r -: 8] = b;
        end
        return res;
    endfunction

    always_comb begin
        col_base = 7'd127 - {col_cnt_q, 5'd0};
        col_a    = src_q[col_base -: 32];
        col_d    = mix_col(col_a, inv_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_cnt_q   <= 2'd0;
            src_q       <= 128'h0;
            inv_q       <= 1'b0;
            res_q       <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        src_q      <= in_state;
                        inv_q      <= in_inv;
                        col_cnt_q  <= 2'd0;
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                    end
                end
                CALC: begin
                    res_q[col_base -: 32] <= col_d;
                    col_cnt_q <= col_cnt_q + 2'd1;
                    if (col_cnt_q == 2'd3) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_state   = res_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: FIPS-197 vectors, latency, backpressure,
// mid-operation reset and back-to-back transfers, checked through a scoreboard.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [1:0]   dbg_state;

    logic [127:0] exp_q[$];
    int checks;
    int errors;

    localparam logic [127:0] V_FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_RED_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V_RED_OUT  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    mix_columns_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_inv     (in_inv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: a negedge with valid && ready means a transfer at the next posedge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", out_state);
            end else begin
                check("scoreboard_out", out_state, exp_q.pop_front());
            end
        end
    end

    // driver: present a vector and wait (bounded) for the accepting edge
    task automatic send(input logic [127:0] st, input logic inv, input logic [127:0] expv);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_state = st;
        in_inv   = inv;
        exp_q.push_back(expv);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] held;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_out_state", out_state, 128'd0);
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);

        // FIPS vector with exact latency, input toggling during CALC, backpressure
        send(V_FIPS_IN, 1'b0, V_FIPS_OUT);
        in_state = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
        in_inv   = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency_valid_e%0d", i), {127'd0, out_valid}, {127'd0, (i == 4)});
        end
        in_valid = 1'b1;
        held = V_FIPS_OUT;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", {127'd0, out_valid}, 128'd1);
            check("stall_out_state", out_state, held);
            check("stall_in_ready", {127'd0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // forward with reduction, then inverse round-trip
        send(V_RED_IN, 1'b0, V_RED_OUT);
        drain();
        send(V_FIPS_OUT, 1'b1, V_FIPS_IN);
        drain();

        // reset asserted at E2 after accept
        out_ready = 1'b0;
        send(V_FIPS_IN, 1'b0, 128'd0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_out_valid", {127'd0, out_valid}, 128'd0);
        check("midreset_out_state", out_state, 128'd0);
        check("midreset_in_ready", {127'd0, in_ready}, 128'd1);
        out_ready = 1'b1;
        send(V_RED_OUT, 1'b1, V_RED_IN);
        drain();

        // back-to-back with in_valid and out_ready held high
        send(V_FIPS_IN, 1'b0, V_FIPS_OUT);
        in_valid = 1'b1;
        in_state = V_FIPS_OUT;
        in_inv   = 1'b1;
        exp_q.push_back(V_FIPS_IN);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("b2b_done_valid", {127'd0, out_valid}, 128'd1);
        @(posedge clk);
        #1;
        check("b2b_idle_in_ready", {127'd0, in_ready}, 128'd1);
        check("b2b_idle_out_valid", {127'd0, out_valid}, 128'd0);
        @(posedge clk);
        #1;
        check("b2b_second_accept", {127'd0, in_ready}, 128'd0);
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded expected finish");
        $fatal(1);
    end

endmodule
